// File: rtl/decode_issue_reg_way0_if.sv
// Decoder-to-execute bundle and handshake for the way-0 issue register.
// The slave view belongs to the issue register; the master view is the surrounding pipeline.
interface decode_issue_reg_way0_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [4:0]        rdAddr_i;
  logic              rdWriteEnable_i;
  logic [DATA_W-1:0] rs1ReadData_i;
  logic [DATA_W-1:0] rs2ReadData_i;
  logic [DATA_W-1:0] imm_i;
  logic [6:0]        opCode_i;
  logic [2:0]        funct3_i;
  logic [6:0]        funct7_i;
  logic [5:0]        shamt_i;
  logic [1:0]        pID_i;
  logic [ADDR_W-1:0] instAddr_i;

  logic              valid_o;
  logic              ready_i;
  logic [4:0]        rdAddr_o;
  logic              rdWriteEnable_o;
  logic [DATA_W-1:0] rs1ReadData_o;
  logic [DATA_W-1:0] rs2ReadData_o;
  logic [DATA_W-1:0] imm_o;
  logic [6:0]        opCode_o;
  logic [2:0]        funct3_o;
  logic [6:0]        funct7_o;
  logic [5:0]        shamt_o;
  logic [1:0]        pID_o;
  logic [ADDR_W-1:0] instAddr_o;

  modport slave (
    input  flush_i, valid_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
           imm_i, opCode_i, funct3_i, funct7_i, shamt_i, pID_i, instAddr_i, ready_i,
    output ready_o, valid_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o,
           imm_o, opCode_o, funct3_o, funct7_o, shamt_o, pID_o, instAddr_o
  );

  modport master (
    output flush_i, valid_i, rdAddr_i, rdWriteEnable_i, rs1ReadData_i, rs2ReadData_i,
           imm_i, opCode_i, funct3_i, funct7_i, shamt_i, pID_i, instAddr_i, ready_i,
    input  ready_o, valid_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o,
           imm_o, opCode_o, funct3_o, funct7_o, shamt_o, pID_o, instAddr_o
  );
endinterface

// File: rtl/decode_issue_reg_way0.sv
// Way-0 decode/execute boundary: 2-entry skid buffer with registered ready and whole-stage flush.
// Outputs come straight from the head register, which is zeroed whenever it holds nothing.
module decode_issue_reg_way0 #(
  parameter int          DATA_W = 64,
  parameter int          ADDR_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input logic                    clk,
  input logic                    rst,
  decode_issue_reg_way0_if.slave bus
);

  typedef struct packed {
    logic [4:0]        rdAddr;
    logic              rdWriteEnable;
    logic [DATA_W-1:0] rs1ReadData;
    logic [DATA_W-1:0] rs2ReadData;
    logic [DATA_W-1:0] imm;
    logic [6:0]        opCode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [5:0]        shamt;
    logic [1:0]        pID;
    logic [ADDR_W-1:0] instAddr;
  } bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t  r_state;
  state_t  w_stateNext;
  bundle_t r_head;
  bundle_t r_skid;
  bundle_t w_headNext;
  bundle_t w_skidNext;
  bundle_t w_in;
  logic    w_push;
  logic    w_pop;

  assign w_in = '{
    rdAddr:        bus.rdAddr_i,
    rdWriteEnable: bus.rdWriteEnable_i,
    rs1ReadData:   bus.rs1ReadData_i,
    rs2ReadData:   bus.rs2ReadData_i,
    imm:           bus.imm_i,
    opCode:        bus.opCode_i,
    funct3:        bus.funct3_i,
    funct7:        bus.funct7_i,
    shamt:         bus.shamt_i,
    pID:           bus.pID_i,
    instAddr:      bus.instAddr_i
  };

  assign w_push = bus.valid_i && bus.ready_o;
  assign w_pop  = bus.valid_o && bus.ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_head  <= w_headNext;
      r_skid  <= w_skidNext;
    end
  end

  // Vacated entries are cleared so a non-valid head always presents zeros.
  always_comb begin
    w_stateNext = r_state;
    w_headNext  = r_head;
    w_skidNext  = r_skid;
    if (bus.flush_i) begin
      w_stateNext = EMPTY;
      w_headNext  = '0;
      w_skidNext  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_stateNext = ONE;
            w_headNext  = w_in;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            w_stateNext = TWO;
            w_skidNext  = w_in;
          end else if (w_pop && !w_push) begin
            w_stateNext = EMPTY;
            w_headNext  = '0;
          end else if (w_push && w_pop) begin
            w_headNext  = w_in;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_stateNext = ONE;
            w_headNext  = r_skid;
            w_skidNext  = '0;
          end
        end
        default: begin
          w_stateNext = EMPTY;
          w_headNext  = '0;
          w_skidNext  = '0;
        end
      endcase
    end
  end

  // The state encoding doubles as the occupancy count.
  always_comb begin
    bus.valid_o         = (r_state != EMPTY);
    bus.ready_o         = !rst && ({30'd0, r_state} < DEPTH);
    bus.rdAddr_o        = r_head.rdAddr;
    bus.rdWriteEnable_o = r_head.rdWriteEnable;
    bus.rs1ReadData_o   = r_head.rs1ReadData;
    bus.rs2ReadData_o   = r_head.rs2ReadData;
    bus.imm_o           = r_head.imm;
    bus.opCode_o        = r_head.opCode;
    bus.funct3_o        = r_head.funct3;
    bus.funct7_o        = r_head.funct7;
    bus.shamt_o         = r_head.shamt;
    bus.pID_o           = r_head.pID;
    bus.instAddr_o      = r_head.instAddr;
  end

endmodule

// File: tb/tb_decode_issue_reg_way0.sv
// Self-checking bench for decode_issue_reg_way0: scenario tasks plus a FIFO scoreboard monitor.
module tb_decode_issue_reg_way0;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [4:0]        rdAddr;
    logic              rdWriteEnable;
    logic [DATA_W-1:0] rs1ReadData;
    logic [DATA_W-1:0] rs2ReadData;
    logic [DATA_W-1:0] imm;
    logic [6:0]        opCode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [5:0]        shamt;
    logic [1:0]        pID;
    logic [ADDR_W-1:0] instAddr;
  } bundle_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    checkEn = 1'b0;
  int      vectors = 0;
  int      miscompares = 0;
  bundle_t sbQ[$];
  bundle_t monObs;

  decode_issue_reg_way0_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  decode_issue_reg_way0 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic bundle_t getOut();
    return '{bus.rdAddr_o, bus.rdWriteEnable_o, bus.rs1ReadData_o, bus.rs2ReadData_o,
             bus.imm_o, bus.opCode_o, bus.funct3_o, bus.funct7_o, bus.shamt_o,
             bus.pID_o, bus.instAddr_o};
  endfunction

  function automatic bundle_t getIn();
    return '{bus.rdAddr_i, bus.rdWriteEnable_i, bus.rs1ReadData_i, bus.rs2ReadData_i,
             bus.imm_i, bus.opCode_i, bus.funct3_i, bus.funct7_i, bus.shamt_i,
             bus.pID_i, bus.instAddr_i};
  endfunction

  function automatic bundle_t randBundle();
    bundle_t b;
    b.rdAddr        = 5'($urandom);
    b.rdWriteEnable = 1'($urandom);
    b.rs1ReadData   = {$urandom, $urandom};
    b.rs2ReadData   = {$urandom, $urandom};
    b.imm           = {$urandom, $urandom};
    b.opCode        = 7'($urandom);
    b.funct3        = 3'($urandom);
    b.funct7        = 7'($urandom);
    b.shamt         = 6'($urandom);
    b.pID           = 2'($urandom);
    b.instAddr      = $urandom;
    return b;
  endfunction

  task automatic applyStimulus(input logic valid, input bundle_t b, input logic readyIn,
                               input logic flush);
    bus.valid_i         = valid;
    bus.ready_i         = readyIn;
    bus.flush_i         = flush;
    bus.rdAddr_i        = b.rdAddr;
    bus.rdWriteEnable_i = b.rdWriteEnable;
    bus.rs1ReadData_i   = b.rs1ReadData;
    bus.rs2ReadData_i   = b.rs2ReadData;
    bus.imm_i           = b.imm;
    bus.opCode_i        = b.opCode;
    bus.funct3_i        = b.funct3;
    bus.funct7_i        = b.funct7;
    bus.shamt_i         = b.shamt;
    bus.pID_i           = b.pID;
    bus.instAddr_i      = b.instAddr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare head/valid/ready mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (checkEn) begin
      monObs = getOut();
      vectors++;
      if (bus.ready_o !== (!rst && (sbQ.size() < 2))) begin
        miscompares++;
        $display("[TB] FAIL mon_ready: got %b expected %b", bus.ready_o, (!rst && (sbQ.size() < 2)));
      end
      vectors++;
      if (bus.valid_o !== (sbQ.size() != 0)) begin
        miscompares++;
        $display("[TB] FAIL mon_valid: got %b expected %b", bus.valid_o, (sbQ.size() != 0));
      end
      vectors++;
      if (sbQ.size() != 0) begin
        if (monObs !== sbQ[0]) begin
          miscompares++;
          $display("[TB] FAIL mon_head: got %h expected %h", monObs, sbQ[0]);
        end
      end else if (monObs !== '0) begin
        miscompares++;
        $display("[TB] FAIL mon_zero: got %h expected 0", monObs);
      end
      if (rst || bus.flush_i) begin
        sbQ.delete();
      end else begin
        if (bus.valid_o && bus.ready_i && sbQ.size() != 0) void'(sbQ.pop_front());
        if (bus.valid_i && bus.ready_o) sbQ.push_back(getIn());
      end
    end
  end

  task automatic test_reset();
    bundle_t z = '0;
    applyStimulus(1'b0, z, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkEn = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready_low: got %b expected 0", bus.ready_o);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.rdWriteEnable_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got valid=%b ready=%b we=%b expected 0 1 0",
               bus.valid_o, bus.ready_o, bus.rdWriteEnable_o);
    end
    tick();
  endtask

  task automatic test_single_push();
    bundle_t b = randBundle();
    b.opCode = 7'h13;
    b.rdAddr = 5'd5;
    b.imm    = '1;
    b.pID    = 2'd1;
    applyStimulus(1'b1, b, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, randBundle(), 1'b1, 1'b0);
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.opCode_o !== 7'h13 || bus.rdAddr_o !== 5'd5 ||
        bus.imm_o !== 64'hFFFF_FFFF_FFFF_FFFF || bus.pID_o !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL single_push: got v=%b op=%h rd=%0d imm=%h pid=%0d expected 1 13 5 ffffffffffffffff 1",
               bus.valid_o, bus.opCode_o, bus.rdAddr_o, bus.imm_o, bus.pID_o);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_drain: got valid=%b expected 0", bus.valid_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bundle_t a = randBundle();
    bundle_t b = randBundle();
    logic [2:0] readySeq;
    applyStimulus(1'b1, a, 1'b0, 1'b0);
    @(negedge clk);
    readySeq[2] = bus.ready_o;
    tick();
    applyStimulus(1'b1, b, 1'b0, 1'b0);
    @(negedge clk);
    readySeq[1] = bus.ready_o;
    tick();
    applyStimulus(1'b1, randBundle(), 1'b0, 1'b0);
    @(negedge clk);
    readySeq[0] = bus.ready_o;
    vectors++;
    if (readySeq !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL bp_ready_seq: got %b expected 110", readySeq);
    end
    vectors++;
    if (getOut() !== a) begin
      miscompares++;
      $display("[TB] FAIL bp_hold_a: got %h expected %h", getOut(), a);
    end
    tick();
    applyStimulus(1'b0, randBundle(), 1'b1, 1'b0);
    tick();
    @(negedge clk);
    vectors++;
    if (getOut() !== b || bus.ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_second_pop: got %h ready=%b expected %h ready=1", getOut(), bus.ready_o, b);
    end
    tick();
  endtask

  task automatic test_streaming();
    bundle_t b;
    for (int i = 0; i < 10; i++) begin
      b = randBundle();
      b.pID = 2'(i % 4);
      applyStimulus(1'b1, b, 1'b1, 1'b0);
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if (bus.valid_o !== 1'b1 || bus.pID_o !== 2'((i - 1) % 4) || bus.ready_o !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL stream_%0d: got v=%b pid=%0d ready=%b expected 1 %0d 1",
                   i, bus.valid_o, bus.pID_o, bus.ready_o, (i - 1) % 4);
        end
      end
      tick();
    end
    applyStimulus(1'b0, randBundle(), 1'b1, 1'b0);
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b1 || bus.pID_o !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL stream_last: got v=%b pid=%0d expected 1 1", bus.valid_o, bus.pID_o);
    end
    tick();
  endtask

  task automatic test_push_pop_one();
    bundle_t a = randBundle();
    bundle_t c = randBundle();
    applyStimulus(1'b1, a, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, c, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, randBundle(), 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (getOut() !== c || bus.valid_o !== 1'b1 || bus.ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pushpop_head: got %h v=%b r=%b expected %h 1 1", getOut(), bus.valid_o, bus.ready_o, c);
    end
    tick();
    applyStimulus(1'b0, randBundle(), 1'b1, 1'b0);
    tick();
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pushpop_drain: got valid=%b expected 0", bus.valid_o);
    end
    tick();
  endtask

  task automatic test_flush();
    applyStimulus(1'b1, randBundle(), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, randBundle(), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, randBundle(), 1'b1, 1'b1);
    @(negedge clk);
    vectors++;
    if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_full: got ready=%b valid=%b expected 0 1", bus.ready_o, bus.valid_o);
    end
    tick();
    applyStimulus(1'b0, randBundle(), 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0 || getOut() !== '0 || bus.ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_cleared: got v=%b out=%h r=%b expected 0 0 1", bus.valid_o, getOut(), bus.ready_o);
    end
    tick();
    applyStimulus(1'b1, randBundle(), 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, randBundle(), 1'b0, 1'b0);
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.rdWriteEnable_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_drops_push: got v=%b we=%b expected 0 0", bus.valid_o, bus.rdWriteEnable_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    applyStimulus(1'b1, randBundle(), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, randBundle(), 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, randBundle(), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_ready: got %b expected 0", bus.ready_o);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || getOut() !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_after: got v=%b r=%b out=%h expected 0 1 0", bus.valid_o, bus.ready_o, getOut());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_backpressure();
    test_streaming();
    test_push_pop_one();
    test_flush();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_issue_reg_way0.md
Name: decode_issue_reg_way0

Overview:
- Way-0 registered boundary between the decoder stage and the execute stage.
- Captures the decoded bundle from the decoder when valid_i && ready_o. Presents it to execute with a valid/ready handshake.
- 2-entry skid buffer, so ready_o is a registered signal and execute back-pressure never creates a combinational ready path into the decoder/IFU.
- Supports a whole-stage flush on redirect.

Parameters:
- DATA_W, 64, width of operand and immediate fields
- ADDR_W, 32, width of instruction address field
- DEPTH, 2, entries; fixed at 2 (skid), other values unsupported

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  discard all held entries this cycle
- valid_i  in  1  decoder bundle valid
- ready_o  out  1  stage can accept; registered, equals (count<2) && !rst
- rdAddr_i / rdAddr_o  in/out  5  destination register
- rdWriteEnable_i / rdWriteEnable_o  in/out  1  rd write enable
- rs1ReadData_i / rs1ReadData_o  in/out  DATA_W  rs1 operand
- rs2ReadData_i / rs2ReadData_o  in/out  DATA_W  rs2 operand
- imm_i / imm_o  in/out  DATA_W  sign-extended immediate
- opCode_i / opCode_o  in/out  7  opcode
- funct3_i / funct3_o  in/out  3  funct3
- funct7_i / funct7_o  in/out  7  funct7
- shamt_i / shamt_o  in/out  6  shift amount
- pID_i / pID_o  in/out  2  packet ID
- instAddr_i / instAddr_o  in/out  ADDR_W  instruction PC
- valid_o  out  1  head entry valid to execute
- ready_i  in  1  execute accepts head

Behaviour:
- push = valid_i && ready_o; pop = valid_o && ready_i.
- Occupancy states EMPTY(0), ONE(1), TWO(2).
  - valid_o = (state != EMPTY).
  - ready_o = (state != TWO), forced 0 while rst is high.
- Transitions, evaluated in priority order:
  - rst -> EMPTY.
  - flush_i -> EMPTY. Any push that cycle is dropped; pop is irrelevant.
  - EMPTY: push -> ONE; else stay.
  - ONE: push && !pop -> TWO; pop && !push -> EMPTY; push && pop -> ONE, with the new bundle as head; else stay.
  - TWO: pop -> ONE, with the second entry promoted to head; no push is possible (ready_o=0).
- Storage: head register + skid register. Outputs are driven directly from the head register; there is no combinational path from any *_i data input to any *_o.
- Latency: a bundle accepted in cycle N is visible on the outputs with valid_o=1 in cycle N+1 at the earliest.
- Ordering: strict FIFO. Bundles leave in acceptance order, and no bundle is duplicated or lost except by flush.
- Data stability: while valid_o && !ready_i, every *_o field holds constant.
- Reset/flush values:
  - valid_o=0.
  - All data outputs 0: rdAddr_o=0, rdWriteEnable_o=0, imm_o=0, opCode_o=0, pID_o=0, etc.
  - Entries are cleared, not just invalidated, so rdWriteEnable_o=0 is guaranteed when valid_o=0.
- Reset mid-operation: held entries are lost. ready_o drops in the same cycle rst is high and returns to 1 in the first cycle after rst deasserts.
- Flush when EMPTY: no effect. Flush in the same cycle as the first cycle after reset: stays EMPTY.
- The data-field contents of an empty entry are don't-care internally, but outputs must read 0 when valid_o=0.

Test Plan:
- Reset then single push: rst 2 cycles; push opCode=0x13, rdAddr=5, imm=0xFFFF_FFFF_FFFF_FFFF, pID=1, ready_i=1.
  -> valid_o=1 next cycle with identical fields; valid_o=0 the cycle after.
- Back-pressure fill: ready_i=0, push A then B.
  -> ready_o=1,1,0; valid_o holds A stable.
  - Raise ready_i: A pops, then B pops on consecutive cycles with ready_o returning to 1 after the first pop.
- Streaming: ready_i=1, valid_i=1 for 10 cycles with pID 0,1,2,3,0...
  -> valid_o continuous from cycle 1, same pID sequence, ready_o never drops.
- Simultaneous push/pop in ONE: state ONE holding A, push C with ready_i=1.
  -> next cycle head=C, state ONE, A consumed exactly once.
- Flush priority: state TWO (A,B) with flush_i=1 and ready_i=1.
  -> next cycle valid_o=0, all outputs 0, ready_o=1. A push asserted with flush_i is dropped.
- Reset mid-stall: state TWO, assert rst 1 cycle.
  -> ready_o=0 during rst, valid_o=0 after, ready_o=1 in the first cycle after rst deasserts.
